instr_mem_ctrl: RTL

INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

---
 rtl/instr_mem_ctrl_pkg.sv | 20 ++
 rtl/instr_mem_ctrl_if.sv | 38 +++
 rtl/instr_mem_ctrl_imem_array.sv | 30 +++
 rtl/instr_mem_ctrl.sv | 95 +++++++++
 4 files changed

// File: rtl/instr_mem_ctrl_pkg.sv
// Shared definitions for the instruction memory controller and the CPU side.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_mem_ctrl_pkg;

  // Default instruction width and memory depth, also used by the CPU.
  localparam int INSTR_W_DEF = 19;
  localparam int DEPTH_DEF   = 128;

  // The wait counter holds up to READ_LATENCY-1, and READ_LATENCY is at most 7.
  localparam int CNT_W = 3;

  // Controller states: program load, ready for a fetch, fetch in flight.
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Fetch and program-load bus between the CPU/loader (master) and the controller (slave).
// Latency: n/a (wires only).
// Backpressure: BUSYWAIT stalls the CPU; READY gates fetches until the program is loaded.
interface instr_mem_ctrl_if
  import instr_mem_ctrl_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) ();

  localparam int AW = $clog2(DEPTH);

  // Fetch side
  logic [31:0]        PC;
  logic               READ;
  logic [INSTR_W-1:0] INSTRUCTION;
  logic               VALID;
  logic               BUSYWAIT;
  logic               FAULT;

  // Program-load side
  logic               LOAD_EN;
  logic [AW-1:0]      LOAD_ADDR;
  logic [INSTR_W-1:0] LOAD_DATA;
  logic               LOAD_DONE;
  logic               READY;

  modport master (
    output PC, READ, LOAD_EN, LOAD_ADDR, LOAD_DATA, LOAD_DONE,
    input  INSTRUCTION, VALID, BUSYWAIT, FAULT, READY
  );

  modport slave (
    input  PC, READ, LOAD_EN, LOAD_ADDR, LOAD_DATA, LOAD_DONE,
    output INSTRUCTION, VALID, BUSYWAIT, FAULT, READY
  );

endinterface

// File: rtl/instr_mem_ctrl_imem_array.sv
// Instruction storage: DEPTH x INSTR_W, one synchronous write port, one asynchronous read port.
// Latency: write lands at the clock edge; read is combinational.
// Backpressure: none; contents are never cleared by reset.
module instr_mem_ctrl_imem_array
  import instr_mem_ctrl_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [INSTR_W-1:0] wr_data_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [INSTR_W-1:0] rd_data_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // Program-load write; deliberately no reset so a loaded program survives RESET.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: program-load phase, then fixed-latency fetches with fault flag.
// Latency: VALID rises READ_LATENCY edges after the accepting edge, one fetch per READ_LATENCY+1 cycles.
// Backpressure: BUSYWAIT follows READ while loading or idle and is held high while a fetch is in flight.
module instr_mem_ctrl
  import instr_mem_ctrl_pkg::*;
#(
  parameter int INSTR_W      = INSTR_W_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int READ_LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  instr_mem_ctrl_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q;
  logic               fault_q;

  logic               wr_en;
  logic               pc_oor;
  logic [INSTR_W-1:0] rd_data;

  // Loads are only honoured during the load phase; stray strobes later are dropped.
  assign wr_en  = (state_q == ST_LOAD) && bus.LOAD_EN;
  assign pc_oor = (pc_q >= 32'(DEPTH));

  instr_mem_ctrl_imem_array #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_imem_array (
    .clk_i     (CLK),
    .wr_en_i   (wr_en),
    .wr_addr_i (bus.LOAD_ADDR),
    .wr_data_i (bus.LOAD_DATA),
    .rd_addr_i (pc_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  // Controller FSM: load phase, fetch acceptance, latency countdown and registered result.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (bus.LOAD_DONE) begin
            state_q <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (bus.READ) begin
            pc_q    <= bus.PC;
            cnt_q   <= CNT_LOAD;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            instr_q <= pc_oor ? '0 : rd_data;
            fault_q <= pc_oor;
            valid_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  // A request seen while loading or idle stalls the CPU in that same cycle.
  assign bus.BUSYWAIT    = (state_q == ST_WAIT) ? 1'b1 : bus.READ;
  assign bus.READY       = (state_q != ST_LOAD);
  assign bus.INSTRUCTION = instr_q;
  assign bus.VALID       = valid_q;
  assign bus.FAULT       = fault_q;

endmodule
